// File: rtl/serial_parallel_multiplier.sv
// Unsigned WIDTH x WIDTH shift-and-add multiplier.
// Multiplicand is used in parallel; the multiplier is consumed LSB first, one bit per clock.
module serial_parallel_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   out,
    output logic                 finish
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        SETUP,
        LOAD,
        CALC,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PW-1:0]   r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_out;
    logic            r_finish;

    logic [PW-1:0]   w_addend;
    logic [PW-1:0]   w_sum;
    logic            w_last;

    assign w_addend = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
    assign w_sum    = r_mplier[0] ? (r_acc + w_addend) : r_acc;
    assign w_last   = (r_cnt == LAST);

    assign out    = r_out;
    assign finish = r_finish;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SETUP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            SETUP:   w_next_state = LOAD;
            LOAD:    w_next_state = CALC;
            CALC:    w_next_state = w_last ? DONE : CALC;
            DONE:    w_next_state = DONE;
            default: w_next_state = SETUP;
        endcase
    end

    // Datapath: operand capture, shift-and-add, result latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_finish <= 1'b0;
        end else begin
            unique case (r_state)
                LOAD: begin
                    r_mcand  <= A;
                    r_mplier <= B;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
                CALC: begin
                    r_acc    <= w_sum;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_out    <= w_sum;
                        r_finish <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parallel_multiplier.sv
// Directed bench for serial_parallel_multiplier.
// Checks latency, products, operand isolation, abort and an exhaustive sweep.
module tb_serial_parallel_multiplier;

    logic       clk;
    logic       reset;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] out;
    logic       finish;

    int errors = 0;
    int checks = 0;

    serial_parallel_multiplier #(.WIDTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .out    (out),
        .finish (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One reset cycle, release, then operands 1 ns later.
    task automatic start_op(input logic [3:0] a, input logic [3:0] b);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        A = a;
        B = b;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        A = 4'd0;
        B = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out !== 8'd0) begin
            errors++;
            $display("FAIL reset_out: got %0d expected 0", out);
        end
        checks++;
        if (finish !== 1'b0) begin
            errors++;
            $display("FAIL reset_finish: got %b expected 0", finish);
        end
    endtask

    task automatic test_latency;
        start_op(4'd13, 4'd11);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (finish !== (e == 6)) begin
                errors++;
                $display("FAIL latency_finish edge %0d: got %b expected %b",
                         e, finish, (e == 6));
            end
            checks++;
            if (out !== ((e == 6) ? 8'd143 : 8'd0)) begin
                errors++;
                $display("FAIL latency_out edge %0d: got %0d expected %0d",
                         e, out, (e == 6) ? 143 : 0);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (finish !== 1'b1 || out !== 8'd143) begin
            errors++;
            $display("FAIL hold: got out=%0d finish=%b expected 143/1", out, finish);
        end
    endtask

    task automatic test_products;
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic [7:0] vp [3];
        va = '{4'd15, 4'd0, 4'd1};
        vb = '{4'd15, 4'd9, 4'd15};
        vp = '{8'hE1, 8'd0, 8'd15};
        for (int k = 0; k < 3; k++) begin
            start_op(va[k], vb[k]);
            repeat (5) @(posedge clk);
            #1;
            checks++;
            if (finish !== 1'b0) begin
                errors++;
                $display("FAIL prod_early %0d: finish=%b expected 0", k, finish);
            end
            @(posedge clk);
            #1;
            checks++;
            if (finish !== 1'b1 || out !== vp[k]) begin
                errors++;
                $display("FAIL prod %0dx%0d: got out=%0d finish=%b expected %0d/1",
                         va[k], vb[k], out, finish, vp[k]);
            end
        end
    endtask

    task automatic test_operand_change;
        start_op(4'd13, 4'd11);
        repeat (4) @(posedge clk);
        #1;
        A = 4'd7;
        B = 4'd7;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (finish !== 1'b1 || out !== 8'd143) begin
            errors++;
            $display("FAIL operand_change: got out=%0d finish=%b expected 143/1",
                     out, finish);
        end
    endtask

    task automatic test_abort;
        start_op(4'd13, 4'd11);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out !== 8'd0 || finish !== 1'b0) begin
            errors++;
            $display("FAIL abort: got out=%0d finish=%b expected 0/0", out, finish);
        end
        reset = 1'b0;
        #1;
        A = 4'd6;
        B = 4'd5;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (finish !== 1'b0) begin
            errors++;
            $display("FAIL abort_early: finish=%b expected 0", finish);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out !== 8'd30 || finish !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: got out=%0d finish=%b expected 30/1",
                     out, finish);
        end
    endtask

    task automatic test_reset_held;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out !== 8'd0 || finish !== 1'b0) begin
                errors++;
                $display("FAIL reset_held cycle %0d: got out=%0d finish=%b expected 0/0",
                         c, out, finish);
            end
        end
    endtask

    task automatic test_sweep;
        logic [7:0] exp;
        int bad_partial;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                exp = 8'(i * j);
                start_op(4'(i), 4'(j));
                bad_partial = 0;
                for (int c = 0; c < 10; c++) begin
                    @(posedge clk);
                    #1;
                    if (finish === 1'b0 && out !== 8'd0) bad_partial++;
                end
                checks++;
                if (bad_partial != 0) begin
                    errors++;
                    $display("FAIL sweep_partial %0dx%0d: %0d cycles with out!=0 before finish",
                             i, j, bad_partial);
                end
                checks++;
                if (finish !== 1'b1 || out !== exp) begin
                    errors++;
                    $display("FAIL sweep %0dx%0d: got out=%0d finish=%b expected %0d/1",
                             i, j, out, finish, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_products;
        test_operand_change;
        test_abort;
        test_reset_held;
        test_sweep;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
